// File: rtl/matmul_tile_scheduler_if.sv
// matmul_tile_scheduler_if: tile-job and writeback handshake between scheduler and block MAC driver
interface matmul_tile_scheduler_if #(parameter int ADDR_W = 16);
  logic              tile_start;
  logic [ADDR_W-1:0] tile_base_a;
  logic [ADDR_W-1:0] tile_base_b;
  logic              acc_clear;
  logic              last_k;
  logic              tile_done;
  logic              wb_start;
  logic [ADDR_W-1:0] wb_base_c;
  logic              wb_done;
  modport master (output tile_start, tile_base_a, tile_base_b, acc_clear, last_k, wb_start, wb_base_c,
                  input tile_done, wb_done);
  modport slave (input tile_start, tile_base_a, tile_base_b, acc_clear, last_k, wb_start, wb_base_c,
                 output tile_done, wb_done);
endinterface

// File: rtl/matmul_tile_scheduler.sv
// matmul_tile_scheduler: walks (i,j,k) 8x8 tile jobs of C=AxB with running-base address registers.
// Optional MATMUL_SCHED_ABORT_EN adds abort input and abort_seen status output.
module matmul_tile_scheduler #(
  parameter int ADDR_W = 16,
  parameter int BLK_W  = 5,
  parameter int TILE   = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [BLK_W-1:0]  m_blk,
  input  logic [BLK_W-1:0]  k_blk,
  input  logic [BLK_W-1:0]  n_blk,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] base_c,
  input  logic [ADDR_W-1:0] lda,
  input  logic [ADDR_W-1:0] ldb,
  input  logic [ADDR_W-1:0] ldc,
  output logic              busy,
  output logic              done,
`ifdef MATMUL_SCHED_ABORT_EN
  input  logic              abort,
  output logic              abort_seen,
`endif
  matmul_tile_scheduler_if.master dp
);
  localparam int LG = $clog2(TILE);
  localparam logic [ADDR_W-1:0] TSTEP = ADDR_W'(TILE);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_TILE, WRITEBACK, WAIT_WB, DONE} state_t;
  state_t state_q, state_d;
  logic [BLK_W-1:0] m_blk_q, m_blk_d, k_blk_q, k_blk_d, n_blk_q, n_blk_d;
  logic [BLK_W-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
  logic [ADDR_W-1:0] base_b_q, base_b_d, lda_s_q, lda_s_d, ldb_s_q, ldb_s_d, ldc_s_q, ldc_s_d;
  logic [ADDR_W-1:0] a_row_q, a_row_d, a_q, a_d, b_col_q, b_col_d, b_q, b_d, c_row_q, c_row_d, c_q, c_d;
  logic tile_start_q, tile_start_d, acc_clear_q, acc_clear_d, last_k_q, last_k_d;
  logic wb_start_q, wb_start_d, busy_q, busy_d, done_q, done_d, abort_hit;
`ifdef MATMUL_SCHED_ABORT_EN
  logic abort_seen_q, abort_seen_d;
  assign abort_hit = abort && state_q != IDLE && state_q != DONE;
  assign abort_seen = abort_seen_q;
`else
  assign abort_hit = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    {m_blk_d, k_blk_d, n_blk_d, i_d, j_d, k_d} = {m_blk_q, k_blk_q, n_blk_q, i_q, j_q, k_q};
    {base_b_d, lda_s_d, ldb_s_d, ldc_s_d} = {base_b_q, lda_s_q, ldb_s_q, ldc_s_q};
    {a_row_d, a_d, b_col_d, b_d, c_row_d, c_d} = {a_row_q, a_q, b_col_q, b_q, c_row_q, c_q};
`ifdef MATMUL_SCHED_ABORT_EN
    abort_seen_d = abort_seen_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        {m_blk_d, k_blk_d, n_blk_d} = {m_blk, k_blk, n_blk};
        {i_d, j_d, k_d} = '0;
        base_b_d = base_b;
        lda_s_d = lda << LG;
        ldb_s_d = ldb << LG;
        ldc_s_d = ldc << LG;
        {a_row_d, a_d} = {base_a, base_a};
        {b_col_d, b_d} = {base_b, base_b};
        {c_row_d, c_d} = {base_c, base_c};
        state_d = (m_blk != '0 && k_blk != '0 && n_blk != '0) ? ISSUE : DONE;
`ifdef MATMUL_SCHED_ABORT_EN
        abort_seen_d = 1'b0;
`endif
      end
      ISSUE: state_d = WAIT_TILE;
      WAIT_TILE: if (dp.tile_done) begin
        if (k_q == k_blk_q - 1'b1) state_d = WRITEBACK;
        else begin
          k_d = k_q + 1'b1;
          a_d = a_q + TSTEP;
          b_d = b_q + ldb_s_q;
          state_d = ISSUE;
        end
      end
      WRITEBACK: state_d = WAIT_WB;
      WAIT_WB: if (dp.wb_done) begin
        k_d = '0;
        if (j_q == n_blk_q - 1'b1) begin
          j_d = '0;
          i_d = i_q + 1'b1;
          a_row_d = a_row_q + lda_s_q;
          a_d = a_row_d;
          {b_col_d, b_d} = {base_b_q, base_b_q};
          c_row_d = c_row_q + ldc_s_q;
          c_d = c_row_d;
        end else begin
          j_d = j_q + 1'b1;
          a_d = a_row_q;
          b_col_d = b_col_q + TSTEP;
          b_d = b_col_d;
          c_d = c_q + TSTEP;
        end
        state_d = (i_q == m_blk_q - 1'b1 && j_q == n_blk_q - 1'b1) ? DONE : ISSUE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_hit) begin
      state_d = DONE;
`ifdef MATMUL_SCHED_ABORT_EN
      abort_seen_d = 1'b1;
`endif
    end
    tile_start_d = state_d == ISSUE;
    acc_clear_d = state_d == ISSUE && k_d == '0;
    last_k_d = state_d == ISSUE && k_d == k_blk_d - 1'b1;
    wb_start_d = state_d == WRITEBACK;
    busy_d = state_d != IDLE;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      {m_blk_q, k_blk_q, n_blk_q, i_q, j_q, k_q} <= '0;
      {base_b_q, lda_s_q, ldb_s_q, ldc_s_q} <= '0;
      {a_row_q, a_q, b_col_q, b_q, c_row_q, c_q} <= '0;
      {tile_start_q, acc_clear_q, last_k_q, wb_start_q, busy_q, done_q} <= '0;
`ifdef MATMUL_SCHED_ABORT_EN
      abort_seen_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      {m_blk_q, k_blk_q, n_blk_q, i_q, j_q, k_q} <= {m_blk_d, k_blk_d, n_blk_d, i_d, j_d, k_d};
      {base_b_q, lda_s_q, ldb_s_q, ldc_s_q} <= {base_b_d, lda_s_d, ldb_s_d, ldc_s_d};
      {a_row_q, a_q, b_col_q, b_q, c_row_q, c_q} <= {a_row_d, a_d, b_col_d, b_d, c_row_d, c_d};
      {tile_start_q, acc_clear_q, last_k_q, wb_start_q, busy_q, done_q} <=
        {tile_start_d, acc_clear_d, last_k_d, wb_start_d, busy_d, done_d};
`ifdef MATMUL_SCHED_ABORT_EN
      abort_seen_q <= abort_seen_d;
`endif
    end
  end
  assign dp.tile_start = tile_start_q;
  assign dp.tile_base_a = a_q;
  assign dp.tile_base_b = b_q;
  assign dp.acc_clear = acc_clear_q;
  assign dp.last_k = last_k_q;
  assign dp.wb_start = wb_start_q;
  assign dp.wb_base_c = c_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// tb_matmul_tile_scheduler: scoreboarded directed test of tile/writeback/done event sequences
module tb_matmul_tile_scheduler;
  localparam int AW = 16;
  localparam int BW = 5;
  logic clock = 0, reset = 1, start = 0;
  logic [BW-1:0] m_blk = 0, k_blk = 0, n_blk = 0;
  logic [AW-1:0] base_a = 0, base_b = 0, base_c = 0, lda = 0, ldb = 0, ldc = 0;
  logic busy, done;
  matmul_tile_scheduler_if #(.ADDR_W(AW)) dp();
`ifdef MATMUL_SCHED_ABORT_EN
  logic abort = 0, abort_seen;
`endif
  matmul_tile_scheduler #(.ADDR_W(AW), .BLK_W(BW), .TILE(8)) dut (
    .clock(clock), .reset(reset), .start(start),
    .m_blk(m_blk), .k_blk(k_blk), .n_blk(n_blk),
    .base_a(base_a), .base_b(base_b), .base_c(base_c),
    .lda(lda), .ldb(ldb), .ldc(ldc),
    .busy(busy), .done(done),
`ifdef MATMUL_SCHED_ABORT_EN
    .abort(abort), .abort_seen(abort_seen),
`endif
    .dp(dp));
  always #5 clock = ~clock;
  typedef struct {int kind; logic [AW-1:0] a; logic [AW-1:0] b; logic clr; logic lst;} ev_t;
  ev_t q[$];
  int total = 0, bad = 0, done_cnt = 0, wb_cnt = 0;
  logic auto_td = 1, auto_wb = 1, man_td = 0, td_p = 0, wb_p = 0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  function automatic void et(logic [AW-1:0] a, logic [AW-1:0] b, logic c, logic l);
    q.push_back('{0, a, b, c, l});
  endfunction
  function automatic void ew(logic [AW-1:0] c);
    q.push_back('{1, c, '0, 1'b0, 1'b0});
  endfunction
  function automatic void ed();
    q.push_back('{2, '0, '0, 1'b0, 1'b0});
  endfunction
  task automatic pop(int kind, logic [AW-1:0] a, logic [AW-1:0] b, logic c, logic l);
    ev_t e;
    if (q.size() == 0) chk("unexpected_event", kind, 32'hff);
    else begin
      e = q.pop_front();
      chk("event_kind", kind, e.kind);
      if (kind != 2) chk("event_addr", a, e.a);
      if (kind == 0) begin
        chk("tile_base_b", b, e.b);
        chk("acc_clear", c, e.clr);
        chk("last_k", l, e.lst);
      end
    end
  endtask
  // datapath model: answers each pulse on the following cycle
  initial begin
    dp.tile_done = 0;
    dp.wb_done = 0;
    forever begin
      @(posedge clock);
      #1;
      dp.tile_done = td_p | man_td;
      dp.wb_done = wb_p;
      td_p = dp.tile_start & auto_td;
      wb_p = dp.wb_start & auto_wb;
    end
  end
  initial forever begin
    @(negedge clock);
    if (dp.tile_start) pop(0, dp.tile_base_a, dp.tile_base_b, dp.acc_clear, dp.last_k);
    if (dp.wb_start) begin
      wb_cnt++;
      pop(1, dp.wb_base_c, '0, 1'b0, 1'b0);
    end
    if (done) begin
      done_cnt++;
      pop(2, '0, '0, 1'b0, 1'b0);
    end
  end
  task automatic go(int m, int k, int n, int la, int lb, int lc);
    @(negedge clock);
    m_blk = BW'(m); k_blk = BW'(k); n_blk = BW'(n);
    base_a = 16'h100; base_b = 16'h400; base_c = 16'h800;
    lda = AW'(la); ldb = AW'(lb); ldc = AW'(lc);
    start = 1;
    @(negedge clock);
    start = 0;
  endtask
  task automatic run(string name, int m, int k, int n, int la, int lb, int lc);
    int d0 = done_cnt;
    go(m, k, n, la, lb, lc);
    for (int c = 0; c < 500 && done_cnt == d0; c++) @(negedge clock);
    chk({name, "_done"}, done_cnt - d0, 1);
    @(negedge clock);
    chk({name, "_busy_after"}, busy, 0);
    chk({name, "_queue_left"}, q.size(), 0);
  endtask
  initial begin
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tile_start", dp.tile_start, 0);
    chk("rst_wb_start", dp.wb_start, 0);
    chk("rst_base_a", dp.tile_base_a, 0);
    @(negedge clock);
    reset = 0;
    et(16'h100, 16'h400, 1, 1); ew(16'h800); ed();
    run("t1", 1, 1, 1, 8, 8, 8);
    et(16'h100, 16'h400, 1, 0); et(16'h108, 16'h440, 0, 1); ew(16'h800);
    et(16'h180, 16'h400, 1, 0); et(16'h188, 16'h440, 0, 1); ew(16'h840); ed();
    run("t2", 2, 2, 1, 16, 8, 8);
    et(16'h100, 16'h400, 1, 0); et(16'h108, 16'h480, 0, 0); et(16'h110, 16'h500, 0, 1); ew(16'h800);
    et(16'h100, 16'h408, 1, 0); et(16'h108, 16'h488, 0, 0); et(16'h110, 16'h508, 0, 1); ew(16'h808); ed();
    run("t3", 1, 3, 2, 32, 16, 16);
    ed();
    go(1, 1, 0, 8, 8, 8);
    chk("t4_done", done, 1);
    chk("t4_busy", busy, 1);
    @(negedge clock);
    chk("t4_busy_low", busy, 0);
    chk("t4_done_low", done, 0);
    chk("t4_queue_left", q.size(), 0);
    auto_td = 0;
    et(16'h100, 16'h400, 1, 1);
    go(1, 1, 1, 8, 8, 8);
    @(negedge clock);
    chk("t5_busy_wait", busy, 1);
    #2 reset = 1;
    #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_tile_start", dp.tile_start, 0);
    chk("t5_rst_base_a", dp.tile_base_a, 0);
    chk("t5_rst_base_b", dp.tile_base_b, 0);
    chk("t5_rst_wb_c", dp.wb_base_c, 0);
    chk("t5_rst_flags", {dp.acc_clear, dp.last_k, dp.wb_start, done}, 0);
    @(negedge clock);
    reset = 0;
    @(negedge clock);
    man_td = 1;
    @(negedge clock);
    man_td = 0;
    repeat (3) @(negedge clock);
    chk("t5_stays_idle", busy, 0);
    chk("t5_queue_left", q.size(), 0);
    auto_td = 1;
    et(16'h100, 16'h400, 1, 1); ew(16'h800); ed();
    run("t5_rerun", 1, 1, 1, 8, 8, 8);
`ifdef MATMUL_SCHED_ABORT_EN
    begin
      int w0 = wb_cnt;
      auto_wb = 0;
      et(16'h100, 16'h400, 1, 0); et(16'h108, 16'h440, 0, 1); ew(16'h800); ed();
      go(2, 2, 1, 16, 8, 8);
      for (int c = 0; c < 200 && wb_cnt == w0; c++) @(negedge clock);
      chk("t6_wb_seen", wb_cnt - w0, 1);
      @(negedge clock);
      abort = 1;
      @(negedge clock);
      abort = 0;
      chk("t6_done", done, 1);
      chk("t6_abort_seen", abort_seen, 1);
      repeat (5) @(negedge clock);
      chk("t6_busy_low", busy, 0);
      chk("t6_abort_held", abort_seen, 1);
      chk("t6_queue_left", q.size(), 0);
      auto_wb = 1;
      et(16'h100, 16'h400, 1, 1); ew(16'h800); ed();
      run("t6_rerun", 1, 1, 1, 8, 8, 8);
      chk("t6_abort_cleared", abort_seen, 0);
    end
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
